// File: rtl/vxe_vpu_disp_pkg.sv
// Shared definitions for the VPU command dispatcher: FSM states, command
// opcodes, ECU indices and the opcode -> target ECU map.
package vxe_vpu_disp_pkg;

    // Dispatcher FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DISP = 2'd1,
        ST_WAIT = 2'd2
    } disp_state_t;

    // Command opcodes (CU_CMD_* definitions)
    localparam logic [4:0] CU_CMD_NOP   = 5'h00;
    localparam logic [4:0] CU_CMD_PROD  = 5'h01;
    localparam logic [4:0] CU_CMD_STORE = 5'h02;
    localparam logic [4:0] CU_CMD_LOAD  = 5'h03;
    localparam logic [4:0] CU_CMD_ACT   = 5'h04;
    localparam logic [4:0] CU_CMD_SYNC  = 5'h05;
    localparam logic [4:0] CU_CMD_MOVE  = 5'h06;

    // ECU indices; ECU_NONE marks ops with no target, ECU_BAD unknown ops
    localparam logic [3:0] ECU_PROD  = 4'd0;
    localparam logic [3:0] ECU_STORE = 4'd1;
    localparam logic [3:0] ECU_LOAD  = 4'd2;
    localparam logic [3:0] ECU_ACT   = 4'd3;
    localparam logic [3:0] ECU_MOVE  = 4'd4;
    localparam logic [3:0] ECU_NONE  = 4'hE;
    localparam logic [3:0] ECU_BAD   = 4'hF;

    localparam int unsigned ECU_MAX = 8;

    // Opcode -> target ECU index (or ECU_NONE / ECU_BAD marker)
    function automatic logic [3:0] cu_cmd_target(input logic [4:0] op);
        logic [3:0] tgt;
        case (op)
            CU_CMD_NOP:   tgt = ECU_NONE;
            CU_CMD_SYNC:  tgt = ECU_NONE;
            CU_CMD_PROD:  tgt = ECU_PROD;
            CU_CMD_STORE: tgt = ECU_STORE;
            CU_CMD_LOAD:  tgt = ECU_LOAD;
            CU_CMD_ACT:   tgt = ECU_ACT;
            CU_CMD_MOVE:  tgt = ECU_MOVE;
            default:      tgt = ECU_BAD;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/vxe_vpu_disp_dec.sv
// Opcode decoder: op -> {valid, none, one-hot ECU select}. Targets whose
// index is not below NR_ECU are reported as unknown (neither valid nor none).
module vxe_vpu_disp_dec
    import vxe_vpu_disp_pkg::*;
#(
    parameter int unsigned NR_ECU = 4
) (
    input  logic [4:0]        op,
    output logic              valid,
    output logic              none,
    output logic [NR_ECU-1:0] onehot
);

    logic [3:0] tgt;

    // Map the opcode onto an attached ECU and build its one-hot select
    always_comb begin
        tgt    = cu_cmd_target(op);
        none   = (tgt == ECU_NONE);
        valid  = (tgt != ECU_NONE) && (tgt != ECU_BAD) && (32'(tgt) < NR_ECU);
        onehot = '0;
        for (int unsigned k = 0; k < NR_ECU; k++) begin
            onehot[k] = valid && (tgt == 4'(k));
        end
    end

endmodule

// File: rtl/vxe_vpu_cmd_disp.sv
// VPU command dispatcher: pops the VPU command FIFO, routes each command to
// one ECU with a single-cycle dispatch pulse and waits for that ECU's done.
// Only one command is ever in flight; all ECUs share the registered cmd bus.
// Optional statistics counters: define VXE_VPU_DISP_STATS_EN.
module vxe_vpu_cmd_disp
    import vxe_vpu_disp_pkg::*;
#(
    parameter int unsigned NR_ECU = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_cmd_vld,
    output logic              o_cmd_rd,
    input  logic [4:0]        i_cmd_op,
    input  logic [2:0]        i_cmd_th,
    input  logic [47:0]       i_cmd_pl,
    output logic [NR_ECU-1:0] o_disp,
    output logic [4:0]        o_cmd_op,
    output logic [2:0]        o_cmd_th,
    output logic [47:0]       o_cmd_pl,
    input  logic [NR_ECU-1:0] i_done,
    output logic              o_busy,
    output logic              o_err,
    input  logic              i_err_clr
`ifdef VXE_VPU_DISP_STATS_EN
    ,
    output logic [31:0]       o_stat_cmds,
    output logic [31:0]       o_stat_busy
`endif
);

    disp_state_t       state_q, state_d;
    logic [NR_ECU-1:0] sel_q, sel_d;
    logic              cmd_rd_d;
    logic [NR_ECU-1:0] disp_d;
    logic [4:0]        op_d;
    logic [2:0]        th_d;
    logic [47:0]       pl_d;
    logic              busy_d;
    logic              err_d;
    logic              bad_op;
    logic              stray_done;

    logic              dec_valid;
    logic              dec_none;
    logic [NR_ECU-1:0] dec_onehot;

    vxe_vpu_disp_dec #(
        .NR_ECU (NR_ECU)
    ) u_dec (
        .op     (i_cmd_op),
        .valid  (dec_valid),
        .none   (dec_none),
        .onehot (dec_onehot)
    );

    // Next-state, pop/dispatch strobes, cmd latch and sticky error
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cmd_rd_d = 1'b0;
        disp_d   = '0;
        op_d     = o_cmd_op;
        th_d     = o_cmd_th;
        pl_d     = o_cmd_pl;
        bad_op   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // While o_cmd_rd is high the FIFO still shows the head being
                // consumed, so a new pop waits one cycle.
                if (i_cmd_vld && !o_cmd_rd) begin
                    cmd_rd_d = 1'b1;
                    op_d     = i_cmd_op;
                    th_d     = i_cmd_th;
                    pl_d     = i_cmd_pl;
                    if (dec_valid) begin
                        sel_d   = dec_onehot;
                        state_d = ST_DISP;
                    end else if (!dec_none) begin
                        bad_op = 1'b1;
                    end
                end
            end
            ST_DISP: begin
                disp_d  = sel_q;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if ((i_done & sel_q) != '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_q == ST_WAIT) begin
            stray_done = ((i_done & ~sel_q) != '0);
        end else begin
            stray_done = (i_done != '0);
        end

        if (bad_op || stray_done) begin
            err_d = 1'b1;
        end else if (i_err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = o_err;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            o_cmd_rd <= 1'b0;
            o_disp   <= '0;
            o_cmd_op <= '0;
            o_cmd_th <= '0;
            o_cmd_pl <= '0;
            o_busy   <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            o_cmd_rd <= cmd_rd_d;
            o_disp   <= disp_d;
            o_cmd_op <= op_d;
            o_cmd_th <= th_d;
            o_cmd_pl <= pl_d;
            o_busy   <= busy_d;
            o_err    <= err_d;
        end
    end

`ifdef VXE_VPU_DISP_STATS_EN
    // Dispatched-command and busy-cycle counters, cleared with the error flag
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            o_stat_cmds <= '0;
            o_stat_busy <= '0;
        end else if (i_err_clr) begin
            o_stat_cmds <= '0;
            o_stat_busy <= '0;
        end else begin
            if (state_q == ST_DISP) begin
                o_stat_cmds <= o_stat_cmds + 32'd1;
            end
            if (o_busy) begin
                o_stat_busy <= o_stat_busy + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vxe_vpu_cmd_disp.sv
// Directed bench for vxe_vpu_cmd_disp; statistics checks are built when
// VXE_VPU_DISP_STATS_EN is defined.
module tb_vxe_vpu_cmd_disp;
    import vxe_vpu_disp_pkg::*;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        i_cmd_vld = 1'b0;
    logic        o_cmd_rd;
    logic [4:0]  i_cmd_op = '0;
    logic [2:0]  i_cmd_th = '0;
    logic [47:0] i_cmd_pl = '0;
    logic [3:0]  o_disp;
    logic [4:0]  o_cmd_op;
    logic [2:0]  o_cmd_th;
    logic [47:0] o_cmd_pl;
    logic [3:0]  i_done = '0;
    logic        o_busy;
    logic        o_err;
    logic        i_err_clr = 1'b0;
`ifdef VXE_VPU_DISP_STATS_EN
    logic [31:0] o_stat_cmds;
    logic [31:0] o_stat_busy;
`endif

    int          n_chk = 0;
    int          n_fail = 0;
    int unsigned bcnt = 0;

    vxe_vpu_cmd_disp #(
        .NR_ECU (4)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .i_cmd_vld   (i_cmd_vld),
        .o_cmd_rd    (o_cmd_rd),
        .i_cmd_op    (i_cmd_op),
        .i_cmd_th    (i_cmd_th),
        .i_cmd_pl    (i_cmd_pl),
        .o_disp      (o_disp),
        .o_cmd_op    (o_cmd_op),
        .o_cmd_th    (o_cmd_th),
        .o_cmd_pl    (o_cmd_pl),
        .i_done      (i_done),
        .o_busy      (o_busy),
        .o_err       (o_err),
        .i_err_clr   (i_err_clr)
`ifdef VXE_VPU_DISP_STATS_EN
        ,
        .o_stat_cmds (o_stat_cmds),
        .o_stat_busy (o_stat_busy)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (o_busy) bcnt++;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #1;
        chk("rst_rd",   64'(o_cmd_rd), 64'd0);
        chk("rst_disp", 64'(o_disp),   64'd0);
        chk("rst_op",   64'(o_cmd_op), 64'd0);
        chk("rst_pl",   64'(o_cmd_pl), 64'd0);
        chk("rst_busy", 64'(o_busy),   64'd0);
        chk("rst_err",  64'(o_err),    64'd0);
        tick(); tick();
        nrst = 1'b1;
        tick();

        // 1: single PROD command, latency and hold
        i_cmd_vld = 1'b1; i_cmd_op = CU_CMD_PROD; i_cmd_th = 3'd3; i_cmd_pl = 48'h1234;
        tick(); // T1
        chk("t1_rd",   64'(o_cmd_rd), 64'd1);
        chk("t1_busy", 64'(o_busy),   64'd1);
        chk("t1_disp", 64'(o_disp),   64'd0);
        chk("t1_op",   64'(o_cmd_op), 64'(CU_CMD_PROD));
        chk("t1_th",   64'(o_cmd_th), 64'd3);
        chk("t1_pl",   64'(o_cmd_pl), 64'h1234);
        i_cmd_vld = 1'b0; i_cmd_op = 5'h1F; i_cmd_th = 3'd0; i_cmd_pl = 48'hDEAD;
        tick(); // T2
        chk("t2_disp", 64'(o_disp),   64'b0001);
        chk("t2_rd",   64'(o_cmd_rd), 64'd0);
        tick(); // T3
        chk("t3_disp", 64'(o_disp),   64'd0);
        chk("t3_busy", 64'(o_busy),   64'd1);
        chk("t3_pl",   64'(o_cmd_pl), 64'h1234);
        chk("t3_th",   64'(o_cmd_th), 64'd3);
        chk("t3_op",   64'(o_cmd_op), 64'(CU_CMD_PROD));
        repeat (4) tick(); // T7
        chk("t7_busy", 64'(o_busy), 64'd1);
        i_done = 4'b0001;
        tick(); // T8
        i_done = '0;
        chk("t8_busy", 64'(o_busy), 64'd0);
        chk("t8_err",  64'(o_err),  64'd0);

        // 2: back-to-back PROD then STORE
        i_cmd_vld = 1'b1; i_cmd_op = CU_CMD_PROD;
        tick();
        chk("b2b_rd1", 64'(o_cmd_rd), 64'd1);
        i_cmd_op = CU_CMD_STORE;
        tick();
        chk("b2b_disp1", 64'(o_disp),   64'b0001);
        chk("b2b_rd_lo", 64'(o_cmd_rd), 64'd0);
        tick();
        chk("b2b_wait_rd", 64'(o_cmd_rd), 64'd0);
        i_done = 4'b0001;
        tick();
        i_done = '0;
        chk("b2b_idle_busy", 64'(o_busy),   64'd0);
        chk("b2b_idle_rd",   64'(o_cmd_rd), 64'd0);
        tick();
        chk("b2b_rd2", 64'(o_cmd_rd), 64'd1);
        chk("b2b_op2", 64'(o_cmd_op), 64'(CU_CMD_STORE));
        i_cmd_vld = 1'b0;
        tick();
        chk("b2b_disp2", 64'(o_disp), 64'b0010);
        tick();
        i_done = 4'b0010;
        tick();
        i_done = '0;
        chk("b2b_done_busy", 64'(o_busy), 64'd0);
        chk("b2b_err",       64'(o_err),  64'd0);

        // 3: unknown opcode, then PROD, then clear
        i_cmd_vld = 1'b1; i_cmd_op = 5'h1F;
        tick();
        chk("bad_rd",   64'(o_cmd_rd), 64'd1);
        chk("bad_err",  64'(o_err),    64'd1);
        chk("bad_busy", 64'(o_busy),   64'd0);
        i_cmd_op = CU_CMD_PROD;
        tick();
        chk("bad_norepop", 64'(o_cmd_rd), 64'd0);
        chk("bad_nodisp",  64'(o_disp),   64'd0);
        tick();
        chk("bad_next_rd", 64'(o_cmd_rd), 64'd1);
        chk("bad_next_op", 64'(o_cmd_op), 64'(CU_CMD_PROD));
        i_cmd_vld = 1'b0;
        tick();
        chk("bad_next_disp", 64'(o_disp), 64'b0001);
        chk("bad_err_hold",  64'(o_err),  64'd1);
        tick();
        i_done = 4'b0001;
        tick();
        i_done = '0;
        chk("bad_next_busy", 64'(o_busy), 64'd0);
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        chk("clr_err", 64'(o_err), 64'd0);

        // NOP: popped and dropped silently
        i_cmd_vld = 1'b1; i_cmd_op = CU_CMD_NOP;
        tick();
        chk("nop_rd",   64'(o_cmd_rd), 64'd1);
        chk("nop_busy", 64'(o_busy),   64'd0);
        chk("nop_err",  64'(o_err),    64'd0);
        i_cmd_vld = 1'b0;
        tick();
        chk("nop_disp", 64'(o_disp), 64'd0);
        chk("nop_idle", 64'(o_busy), 64'd0);

        // Opcode whose ECU index is beyond NR_ECU is unknown
        i_cmd_vld = 1'b1; i_cmd_op = CU_CMD_MOVE;
        tick();
        i_cmd_vld = 1'b0;
        chk("move_err",  64'(o_err),  64'd1);
        chk("move_busy", 64'(o_busy), 64'd0);
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;

        // 4: unexpected done while waiting on ECU 0
        i_cmd_vld = 1'b1; i_cmd_op = CU_CMD_PROD;
        tick();
        i_cmd_vld = 1'b0;
        tick();
        i_done = 4'b0100;
        tick();
        i_done = '0;
        chk("stray_err",  64'(o_err),  64'd1);
        chk("stray_busy", 64'(o_busy), 64'd1);
        i_done = 4'b0001;
        tick();
        i_done = '0;
        chk("stray_done_busy", 64'(o_busy), 64'd0);
        chk("stray_err_hold",  64'(o_err),  64'd1);
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        chk("stray_clr", 64'(o_err), 64'd0);

        // Own done together with another done: completes and flags error
        i_cmd_vld = 1'b1; i_cmd_op = CU_CMD_STORE;
        tick();
        i_cmd_vld = 1'b0;
        tick();
        chk("dual_disp", 64'(o_disp), 64'b0010);
        i_done = 4'b0011;
        tick();
        i_done = '0;
        chk("dual_busy", 64'(o_busy), 64'd0);
        chk("dual_err",  64'(o_err),  64'd1);

        // Clear together with an error event (done in IDLE): set wins
        i_err_clr = 1'b1; i_done = 4'b1000;
        tick();
        i_done = '0;
        chk("setwins_err", 64'(o_err), 64'd1);
        tick();
        i_err_clr = 1'b0;
        chk("clr2_err", 64'(o_err), 64'd0);
        i_done = 4'b1000;
        tick();
        i_done = '0;
        chk("idle_done_err",  64'(o_err),  64'd1);
        chk("idle_done_busy", 64'(o_busy), 64'd0);
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;

        // 5: asynchronous reset while waiting
        i_cmd_vld = 1'b1; i_cmd_op = CU_CMD_PROD; i_cmd_pl = 48'hABCD;
        tick();
        i_cmd_vld = 1'b0;
        tick();
        tick();
        chk("prerst_busy", 64'(o_busy), 64'd1);
        #2 nrst = 1'b0;
        #1;
        chk("arst_busy", 64'(o_busy),   64'd0);
        chk("arst_rd",   64'(o_cmd_rd), 64'd0);
        chk("arst_disp", 64'(o_disp),   64'd0);
        chk("arst_op",   64'(o_cmd_op), 64'd0);
        chk("arst_pl",   64'(o_cmd_pl), 64'd0);
        @(posedge clk);
        #1 nrst = 1'b1;
        i_cmd_vld = 1'b1; i_cmd_op = CU_CMD_STORE;
        tick();
        chk("post_rd", 64'(o_cmd_rd), 64'd1);
        i_cmd_vld = 1'b0;
        tick();
        chk("post_disp", 64'(o_disp), 64'b0010);
        tick();
        i_done = 4'b0010;
        tick();
        i_done = '0;
        chk("post_busy", 64'(o_busy), 64'd0);
        chk("post_err",  64'(o_err),  64'd0);

`ifdef VXE_VPU_DISP_STATS_EN
        // 6: ten PROD commands, done five cycles after each dispatch
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        chk("stat_clr_cmds", 64'(o_stat_cmds), 64'd0);
        chk("stat_clr_busy", 64'(o_stat_busy), 64'd0);
        bcnt = 0;
        for (int i = 0; i < 10; i++) begin
            i_cmd_vld = 1'b1; i_cmd_op = CU_CMD_PROD;
            tick();
            i_cmd_vld = 1'b0;
            tick();
            repeat (5) tick();
            i_done = 4'b0001;
            tick();
            i_done = '0;
        end
        chk("stat_cmds",      64'(o_stat_cmds), 64'd10);
        chk("stat_busy",      64'(o_stat_busy), 64'd70);
        chk("stat_busy_seen", 64'(o_stat_busy), 64'(bcnt));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
